// File: rtl/cacheline_adapter_if.sv
// ============================================================================
// Module      : cacheline_adapter_if
// Description : Cache-side (dfp) and memory-side (mem) signals of the line
//               adapter, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cacheline_adapter_if;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;

    // slave: the adapter; master: the environment (cache and memory models)
    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  mem_ready, mem_rdata, mem_rvalid,
        output dfp_rdata, dfp_resp,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output mem_ready, mem_rdata, mem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cacheline_adapter.sv
// ============================================================================
// Module      : cacheline_adapter
// Description : Splits 256-bit cache line requests into 4 x 64-bit memory
//               bursts and assembles returning read beats into a line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adapter (
    input  wire logic          clk,
    input  wire logic          rst,
    cacheline_adapter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_DATA = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [255:0]  r_wline;
    logic [255:0]  r_line;
    logic          r_resp;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [63:0]   r_mem_wdata;

    logic [1:0]    w_cnt_nxt;
    logic          w_unused;

    assign w_cnt_nxt = r_cnt + 2'd1;
    assign w_unused  = &{1'b0, bus.dfp_addr[4:0]};

    assign bus.dfp_rdata = r_line;
    assign bus.dfp_resp  = r_resp;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_addr      <= 32'd0;
            r_wline     <= 256'd0;
            r_line      <= 256'd0;
            r_resp      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Write-back takes priority so a dirty victim leaves before the fill.
                    if (bus.dfp_write) begin
                        r_addr      <= {bus.dfp_addr[31:5], 5'd0};
                        r_wline     <= bus.dfp_wdata;
                        r_cnt       <= 2'd0;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= bus.dfp_wdata[63:0];
                        r_state     <= S_WR_DATA;
                    end else if (bus.dfp_read) begin
                        r_addr     <= {bus.dfp_addr[31:5], 5'd0};
                        r_cnt      <= 2'd0;
                        r_mem_read <= 1'b1;
                        r_state    <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (bus.mem_ready) begin
                        r_mem_read <= 1'b0;
                        r_cnt      <= 2'd0;
                        r_state    <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (bus.mem_rvalid) begin
                        r_line[{r_cnt, 6'd0} +: 64] <= bus.mem_rdata;
                        r_cnt <= w_cnt_nxt;
                        if (r_cnt == 2'd3) begin
                            r_resp  <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (bus.mem_ready) begin
                        r_cnt <= w_cnt_nxt;
                        if (r_cnt == 2'd3) begin
                            r_mem_write <= 1'b0;
                            r_resp      <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_wdata <= r_wline[{w_cnt_nxt, 6'd0} +: 64];
                        end
                    end
                end
                S_RESP: begin
                    r_resp  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Scoreboard-driven bench for cacheline_adapter read fills,
//               write-backs, back-to-back traffic and mid-burst reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if bus ();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_line_q[$];
    logic [63:0]  exp_beat_q[$];
    logic [255:0] last_line = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dfp_addr   = '0;
        bus.dfp_read   = 1'b0;
        bus.dfp_write  = 1'b0;
        bus.dfp_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
    endtask

    // Memory responds to a read request with ready after ready_wait idle cycles,
    // then returns beats every (gap+1) cycles.
    task automatic run_read(input string name, input logic [31:0] addr, input logic [255:0] line,
                            input int ready_wait, input int gap, input int exp_resp);
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
        int resp_off;
        int wr_seen;
        int first;
        int idx;
        exp_addr = {addr[31:5], 5'd0};
        resp_off = -1;
        wr_seen  = 0;
        first    = ready_wait + 2;
        exp_line_q.delete();
        step();
        bus.dfp_write  = 1'b0;
        bus.dfp_read   = 1'b1;
        bus.dfp_addr   = addr;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        exp_line_q.push_back(line);
        for (int k = 1; k <= exp_resp + 4 && resp_off < 0; k++) begin
            step();
            bus.dfp_addr = 32'hDEAD_BEEF;
            if (bus.mem_write === 1'b1) wr_seen++;
            if (k <= ready_wait + 1) begin
                checks++;
                if (bus.mem_read !== 1'b1 || bus.mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s_req_hold cyc %0d got read=%b addr=%h exp read=1 addr=%h",
                             name, k, bus.mem_read, bus.mem_addr, exp_addr);
                end
            end
            if (bus.dfp_resp === 1'b1) begin
                resp_off = k;
                checks++;
                if (exp_line_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_rdata got unexpected resp exp none", name);
                end else begin
                    exp_line = exp_line_q.pop_front();
                    if (bus.dfp_rdata !== exp_line) begin
                        errors++;
                        $display("FAIL %s_rdata got %h exp %h", name, bus.dfp_rdata, exp_line);
                    end
                end
                last_line = line;
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = 1'b0;
            end else begin
                bus.mem_ready  = (k >= ready_wait + 1);
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                idx = k - first;
                if (idx >= 0 && (idx % (gap + 1)) == 0 && (idx / (gap + 1)) < 4) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = line[(idx / (gap + 1)) * 64 +: 64];
                end
            end
        end
        checks++;
        if (resp_off != exp_resp) begin
            errors++;
            $display("FAIL %s_resp_cycle got %0d exp %0d", name, resp_off, exp_resp);
        end
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL %s_no_write got %0d write cycles exp 0", name, wr_seen);
        end
        step();
        bus.dfp_read = 1'b0;
        checks++;
        if (bus.dfp_resp !== 1'b0 || bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_resp got resp=%b read=%b exp 0 0", name, bus.dfp_resp, bus.mem_read);
        end
    endtask

    // Returns in the cycle dfp_resp is observed so a following request lands at R+1.
    task automatic run_write(input string name, input logic [31:0] addr, input logic [255:0] line,
                             input int stall_beat, input bit with_read, input int exp_resp);
        logic [31:0] exp_addr;
        logic [63:0] exp_beat;
        int accepted;
        int resp_off;
        int rd_seen;
        bit stalled;
        bit check_hold;
        exp_addr   = {addr[31:5], 5'd0};
        accepted   = 0;
        resp_off   = -1;
        rd_seen    = 0;
        stalled    = 1'b0;
        check_hold = 1'b0;
        exp_beat_q.delete();
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(line[i*64 +: 64]);
        step();
        bus.dfp_write  = 1'b1;
        bus.dfp_read   = with_read;
        bus.dfp_addr   = addr;
        bus.dfp_wdata  = line;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        for (int k = 1; k <= exp_resp + 4 && resp_off < 0; k++) begin
            step();
            bus.dfp_addr  = 32'hFFFF_FFE0;
            bus.dfp_wdata = ~line;
            if (bus.mem_read === 1'b1) rd_seen++;
            if (check_hold) begin
                check_hold = 1'b0;
                checks++;
                if (bus.mem_write !== 1'b1 || bus.mem_wdata !== line[stall_beat*64 +: 64]) begin
                    errors++;
                    $display("FAIL %s_stall_hold got write=%b data=%h exp write=1 data=%h",
                             name, bus.mem_write, bus.mem_wdata, line[stall_beat*64 +: 64]);
                end
            end
            if (bus.dfp_resp === 1'b1) begin
                resp_off = k;
                if (with_read) begin
                    checks++;
                    if (bus.dfp_rdata !== last_line) begin
                        errors++;
                        $display("FAIL %s_rdata_untouched got %h exp %h", name, bus.dfp_rdata, last_line);
                    end
                end
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = 1'b0;
            end else begin
                if (bus.mem_write === 1'b1) begin
                    checks++;
                    if (bus.mem_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL %s_addr got %h exp %h", name, bus.mem_addr, exp_addr);
                    end
                    if (accepted == stall_beat && !stalled) begin
                        stalled       = 1'b1;
                        check_hold    = 1'b1;
                        bus.mem_ready = 1'b0;
                    end else begin
                        bus.mem_ready = 1'b1;
                        accepted++;
                        checks++;
                        if (exp_beat_q.size() == 0) begin
                            errors++;
                            $display("FAIL %s_extra_beat got %h exp none", name, bus.mem_wdata);
                        end else begin
                            exp_beat = exp_beat_q.pop_front();
                            if (bus.mem_wdata !== exp_beat) begin
                                errors++;
                                $display("FAIL %s_beat%0d got %h exp %h", name, accepted - 1, bus.mem_wdata, exp_beat);
                            end
                        end
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                end
                bus.mem_rvalid = with_read;
                bus.mem_rdata  = 64'h5A5A_A5A5_0F0F_F0F0;
            end
        end
        checks++;
        if (resp_off != exp_resp) begin
            errors++;
            $display("FAIL %s_resp_cycle got %0d exp %0d", name, resp_off, exp_resp);
        end
        checks++;
        if (accepted != 4) begin
            errors++;
            $display("FAIL %s_beat_count got %0d exp 4", name, accepted);
        end
        checks++;
        if (rd_seen != 0) begin
            errors++;
            $display("FAIL %s_no_read got %0d read cycles exp 0", name, rd_seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL reset_dfp_resp got %b exp 0", bus.dfp_resp); end
        checks++;
        if (bus.dfp_rdata !== 256'd0) begin errors++; $display("FAIL reset_dfp_rdata got %h exp 0", bus.dfp_rdata); end
        checks++;
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", bus.mem_read); end
        checks++;
        if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", bus.mem_write); end
        checks++;
        if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
        checks++;
        if (bus.mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", bus.mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_read_fill();
        run_read("read_fill", 32'h1234_567F,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 6);
    endtask

    task automatic test_read_gaps();
        run_read("read_gaps", 32'h0000_0440,
                 {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                  64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001}, 3, 1, 12);
    endtask

    task automatic test_write_back();
        logic [255:0] wl;
        wl = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        run_write("write_back", 32'h0000_0100, wl, -1, 1'b0, 5);
        run_write("write_stall", 32'h0000_0100, wl, 2, 1'b0, 6);
    endtask

    task automatic test_back_to_back();
        run_write("b2b_write", 32'h0000_0180,
                  {64'hB3B3, 64'hB2B2, 64'hB1B1, 64'hB0B0}, -1, 1'b0, 5);
        run_read("b2b_fill", 32'h0000_0200,
                 {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707,
                  64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505}, 0, 0, 6);
    endtask

    task automatic test_reset_mid_read();
        int resp_seen;
        int rd_seen;
        int nonzero;
        resp_seen = 0;
        rd_seen   = 0;
        nonzero   = 0;
        step();
        bus.dfp_read  = 1'b1;
        bus.dfp_addr  = 32'h0000_0300;
        bus.mem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 4) begin
                checks++;
                if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.dfp_resp !== 1'b0 ||
                    bus.dfp_rdata !== 256'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 64'd0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs got read=%b write=%b resp=%b addr=%h rdata_nz=%b exp all 0",
                             bus.mem_read, bus.mem_write, bus.dfp_resp, bus.mem_addr, |bus.dfp_rdata);
                end
                rst          = 1'b0;
                bus.dfp_read = 1'b0;
            end
            if (k >= 4) begin
                if (bus.dfp_resp === 1'b1) resp_seen++;
                if (bus.mem_read === 1'b1) rd_seen++;
                if (bus.dfp_rdata !== 256'd0) nonzero++;
            end
            bus.mem_ready  = (k == 1);
            bus.mem_rvalid = (k >= 2 && k <= 6);
            bus.mem_rdata  = 64'hC0DE_0000_0000_0000 | 64'(k);
            if (k == 3) rst = 1'b1;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b0;
        checks++;
        if (resp_seen != 0) begin errors++; $display("FAIL rst_mid_no_resp got %0d exp 0", resp_seen); end
        checks++;
        if (rd_seen != 0) begin errors++; $display("FAIL rst_mid_no_read got %0d exp 0", rd_seen); end
        checks++;
        if (nonzero != 0) begin errors++; $display("FAIL rst_mid_rdata_clear got %0d nonzero cycles exp 0", nonzero); end
        run_read("rst_recover", 32'h0000_0300,
                 {64'h9999_0003_0000_0000, 64'h9999_0002_0000_0000,
                  64'h9999_0001_0000_0000, 64'h9999_0000_0000_0000}, 1, 0, 7);
    endtask

    task automatic test_simultaneous();
        run_write("simul_write", 32'h0000_0500,
                  {64'hE3E3_E3E3, 64'hE2E2_E2E2, 64'hE1E1_E1E1, 64'hE0E0_E0E0}, -1, 1'b1, 5);
        run_read("simul_read", 32'h0000_0500,
                 {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                  64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000}, 0, 0, 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_fill();
        test_read_gaps();
        test_write_back();
        test_back_to_back();
        test_reset_mid_read();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
